// File: rtl/nic_link_pkg.sv
// Shared constants and flit record for the NIC injection link.
// Latency: n/a (types and constants only).
// Backpressure: n/a; per-channel credit depth is N_CREDIT.
package nic_link_pkg;

    localparam int N_CHANNEL      = 6;   // channels / virtual channels on the link
    localparam int N_BITS_POINTER = 3;   // channel id width, 2**N_BITS_POINTER >= N_CHANNEL
    localparam int FLIT_WIDTH     = 64;  // flit payload width
    localparam int N_CREDIT       = 4;   // router input buffer depth per channel
    localparam int N_BITS_CREDIT  = 3;   // credit counter width, holds N_CREDIT

    typedef logic [N_BITS_CREDIT-1:0]  credit_t;
    typedef logic [N_BITS_POINTER-1:0] vc_t;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        vc_t                   vc;
    } flit_t;

endpackage

// File: rtl/link_credit_counter.sv
// Single-channel credit counter: decrement on send, increment on return, saturating at N_CREDIT.
// Latency: count updates on the next edge; has_credit/overflow are combinational views.
// Backpressure: has_credit=0 tells the parent to mask this channel's request.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (count loads N_CREDIT)
//   dec         one credit consumed this cycle (only asserted when has_credit=1)
//   inc         one credit returned this cycle
//   has_credit  count != 0
//   overflow    a lone return arrived while already holding N_CREDIT
module link_credit_counter
    import nic_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc,
    output logic has_credit,
    output logic overflow
);

    localparam credit_t CREDIT_MAX = credit_t'(N_CREDIT);

    credit_t count;

    // dec and inc together cancel, which is how the last credit can be
    // spent and returned in the same cycle without touching the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CREDIT_MAX;
        end else if (dec && !inc) begin
            count <= count - credit_t'(1);
        end else if (inc && !dec && (count != CREDIT_MAX)) begin
            count <= count + credit_t'(1);
        end
    end

    assign has_credit = (count != '0);
    assign overflow   = inc && !dec && (count == CREDIT_MAX);

endmodule

// File: rtl/link_output_stage.sv
// Injection-side link stage: builds allocator requests, pops the granted FIFO and registers the flit onto the link.
// Latency: requests/pop combinational; flit_o/flit_valid_o/flit_vc_o one cycle after an accepted grant.
// Backpressure: per-channel credits; a channel with 0 credits drops its request until the router returns one.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fifo_valid_i      per-channel FIFO non-empty
//   fifo_data_i       per-channel head flits, channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   fifo_pop_o        one-hot pop toward the FIFOs (combinational)
//   r_la_o            request vector to the link allocator (combinational)
//   g_la_i            allocator grant valid
//   g_channel_id_i    granted channel id
//   flit_o            link flit (registered)
//   flit_valid_o      link flit valid (registered)
//   flit_vc_o         channel id of flit_o (registered)
//   credit_valid_i    router returns one credit
//   credit_vc_i       channel of the returned credit
//   error_o           sticky protocol error, cleared only by rst
//   stat_flits_o      accepted grants, wraps at 2**32 (LINK_OUTPUT_STAGE_STATS_EN only)
//   stat_stall_o      cycles with a non-empty FIFO on a 0-credit channel (LINK_OUTPUT_STAGE_STATS_EN only)
//
// Optional feature macro: LINK_OUTPUT_STAGE_STATS_EN adds the two statistics counters.
module link_output_stage
    import nic_link_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_CHANNEL-1:0]              fifo_valid_i,
    input  logic [N_CHANNEL*FLIT_WIDTH-1:0]   fifo_data_i,
    output logic [N_CHANNEL-1:0]              fifo_pop_o,
    output logic [N_CHANNEL-1:0]              r_la_o,
    input  logic                              g_la_i,
    input  logic [N_BITS_POINTER-1:0]         g_channel_id_i,
    output logic [FLIT_WIDTH-1:0]             flit_o,
    output logic                              flit_valid_o,
    output logic [N_BITS_POINTER-1:0]         flit_vc_o,
    input  logic                              credit_valid_i,
    input  logic [N_BITS_POINTER-1:0]         credit_vc_i,
    output logic                              error_o
`ifdef LINK_OUTPUT_STAGE_STATS_EN
    ,
    output logic [31:0]                       stat_flits_o,
    output logic [31:0]                       stat_stall_o
`endif
);

    logic [N_CHANNEL-1:0]  grant_hit;
    logic [N_CHANNEL-1:0]  credit_hit;
    logic [N_CHANNEL-1:0]  has_credit;
    logic [N_CHANNEL-1:0]  overflow;
    logic [FLIT_WIDTH-1:0] head_dat;
    logic                  grant_ok;
    logic                  grant_err;
    logic                  credit_err;
    flit_t                 flit_q;
    logic                  flit_vld_q;
    logic                  error_q;

    // Decode ids by comparison against each channel index: an out-of-range
    // id simply matches nothing, so no array is ever indexed out of bounds.
    always_comb begin
        grant_hit  = '0;
        credit_hit = '0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            grant_hit[i]  = g_la_i && (g_channel_id_i == N_BITS_POINTER'(i));
            credit_hit[i] = credit_valid_i && (credit_vc_i == N_BITS_POINTER'(i));
        end
    end

    assign r_la_o     = fifo_valid_i & has_credit;
    assign fifo_pop_o = grant_hit & r_la_o;
    assign grant_ok   = |fifo_pop_o;
    // Any grant that does not turn into a pop is a protocol violation by the allocator.
    assign grant_err  = g_la_i && !grant_ok;
    assign credit_err = credit_valid_i && !(|credit_hit);

    // fifo_pop_o is one-hot or zero, so an AND-OR mux is sufficient.
    always_comb begin
        head_dat = '0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            if (fifo_pop_o[i]) begin
                head_dat = head_dat | fifo_data_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < N_CHANNEL; g++) begin : g_credit
        link_credit_counter u_credit (
            .clk        (clk),
            .rst        (rst),
            .dec        (fifo_pop_o[g]),
            .inc        (credit_hit[g]),
            .has_credit (has_credit[g]),
            .overflow   (overflow[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_q     <= '0;
            flit_vld_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            flit_vld_q <= grant_ok;
            if (grant_ok) begin
                flit_q.data <= head_dat;
                flit_q.vc   <= g_channel_id_i;
            end
            error_q <= error_q || grant_err || credit_err || (|overflow);
        end
    end

    assign flit_o       = flit_q.data;
    assign flit_vc_o    = flit_q.vc;
    assign flit_valid_o = flit_vld_q;
    assign error_o      = error_q;

`ifdef LINK_OUTPUT_STAGE_STATS_EN
    logic stall;

    // A stall is a ready FIFO starved by the router, not an idle channel.
    assign stall = |(fifo_valid_i & ~has_credit);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flits_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (grant_ok) stat_flits_o <= stat_flits_o + 32'd1;
            if (stall)    stat_stall_o <= stat_stall_o + 32'd1;
        end
    end
`endif

endmodule
